inst_fetch_queue: RTL

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

---
 rtl/inst_fetch_queue_pkg.sv | 15 +
 rtl/iq_lane_compact.sv | 50 +++++
 rtl/inst_fetch_queue.sv | 125 ++++++++++++
 3 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// +----------------------------------------------------------------------------+
// | inst_fetch_queue_pkg : shared defaults for the instruction fetch queue     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package inst_fetch_queue_pkg;

  localparam int IFQ_DEPTH  = 8;
  localparam int IFQ_LANES  = 2;
  localparam int IFQ_DATA_W = 64;

endpackage : inst_fetch_queue_pkg

`default_nettype wire

// File: rtl/iq_lane_compact.sv
// +----------------------------------------------------------------------------+
// | iq_lane_compact : packs sparse enqueue lanes into consecutive write slots  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module iq_lane_compact
  import inst_fetch_queue_pkg::*;
#(
  parameter int LANES  = IFQ_LANES,
  parameter int DATA_W = IFQ_DATA_W
) (
  input  logic [LANES-1:0]              valid_i,
  input  logic [LANES*DATA_W-1:0]       data_i,
  output logic [LANES-1:0]              slot_valid_o,
  output logic [LANES*DATA_W-1:0]       slot_data_o,
  output logic [$clog2(LANES+1)-1:0]    n_enq_o
);

  localparam int DCW = $clog2(LANES + 1);

  logic [DCW-1:0] pos [LANES];
  logic [DCW-1:0] run;

  // pos[k] is the number of valid lanes below k, i.e. the slot lane k lands in.
  always_comb begin
    run = '0;
    for (int k = 0; k < LANES; k++) begin
      pos[k] = run;
      run    = run + DCW'(valid_i[k]);
    end
    n_enq_o = run;
  end

  always_comb begin
    slot_valid_o = '0;
    slot_data_o  = '0;
    for (int j = 0; j < LANES; j++) begin
      for (int k = 0; k < LANES; k++) begin
        if (valid_i[k] && (pos[k] == DCW'(j))) begin
          slot_valid_o[j]                   = 1'b1;
          slot_data_o[j*DATA_W +: DATA_W]   = data_i[k*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule : iq_lane_compact

`default_nettype wire

// File: rtl/inst_fetch_queue.sv
// +----------------------------------------------------------------------------+
// | inst_fetch_queue : multi-lane circular instruction queue, fetch to issue   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH  = IFQ_DEPTH,
  parameter int LANES  = IFQ_LANES,
  parameter int DATA_W = IFQ_DATA_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [LANES-1:0]              enq_valid_i,
  input  logic [LANES*DATA_W-1:0]       enq_data_i,
  output logic                          allowin_o,
  input  logic [$clog2(LANES+1)-1:0]    deq_count_i,
  output logic [LANES-1:0]              deq_valid_o,
  output logic [LANES*DATA_W-1:0]       deq_data_o,
  input  logic                          flush_i,
  output logic [$clog2(DEPTH+1)-1:0]    count_o,
  output logic                          err_o
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int DCW = $clog2(LANES + 1);

  localparam logic [CW:0]   C_DEPTH_X = (CW+1)'(DEPTH);
  localparam logic [CW:0]   C_LANES_X = (CW+1)'(LANES);
  localparam logic [CW-1:0] C_LANES   = CW'(LANES);

  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [LANES-1:0]        slot_valid;
  logic [LANES*DATA_W-1:0] slot_data;
  logic [DCW-1:0]          n_enq;

  logic [CW-1:0] deq_lim;
  logic [CW-1:0] deq_req;
  logic [CW-1:0] deq_eff;
  logic [CW-1:0] n_acc;
  logic [CW:0]   room;
  logic          over;
  logic          wr_en;

  iq_lane_compact #(
    .LANES  (LANES),
    .DATA_W (DATA_W)
  ) u_compact (
    .valid_i      (enq_valid_i),
    .data_i       (enq_data_i),
    .slot_valid_o (slot_valid),
    .slot_data_o  (slot_data),
    .n_enq_o      (n_enq)
  );

  // Room counts entries freed by this cycle's dequeue, so a full queue can still accept.
  always_comb begin
    deq_lim   = (count_q < C_LANES) ? count_q : C_LANES;
    deq_req   = CW'(deq_count_i);
    over      = deq_req > deq_lim;
    deq_eff   = over ? deq_lim : deq_req;
    room      = C_DEPTH_X - {1'b0, count_q} + {1'b0, deq_eff};
    allowin_o = room >= C_LANES_X;
    wr_en     = allowin_o & ~flush_i;
    n_acc     = wr_en ? CW'(n_enq) : '0;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = err_q | over;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(deq_eff);
      tail_d  = tail_q + PW'(n_acc);
      count_d = count_q + n_acc - deq_eff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Storage carries no reset; unread entries are masked by deq_valid_o.
  always_ff @(posedge clk) begin
    for (int j = 0; j < LANES; j++) begin
      if (wr_en && slot_valid[j]) begin
        mem_q[tail_q + PW'(j)] <= slot_data[j*DATA_W +: DATA_W];
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_deq
    assign deq_valid_o[k]                  = count_q > CW'(k);
    assign deq_data_o[k*DATA_W +: DATA_W]  = mem_q[head_q + PW'(k)];
  end

  assign count_o = count_q;
  assign err_o   = err_q;

endmodule : inst_fetch_queue

`default_nettype wire
